// File: rtl/bus_arbiter.sv
// Two-core snooping bus arbiter: round-robin ownership, then snoop, data transfer and
// invalidate phases. Outputs are Moore-decoded from the registered transaction state.
module bus_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] bico0,
    input  logic [ADDR_W-1:0] bico1,
    input  logic              found0,
    input  logic              found1,
    input  logic              u_rdy,
    output logic              grant0,
    output logic              grant1,
    output logic [ADDR_W-1:0] boci,
    output logic              search0,
    output logic              search1,
    output logic              inval0,
    output logic              inval1,
    output logic [1:0]        datasel0,
    output logic [1:0]        datasel1,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SNOOP   = 3'd1,
        S_XFER    = 3'd2,
        S_INVAL   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ_MISS  = 2'b00;
    localparam logic [1:0] OP_WRITE_MISS = 2'b01;
    localparam logic [1:0] OP_INVALIDATE = 2'b10;
    localparam logic [1:0] OP_EVICT      = 2'b11;
    localparam logic [1:0] SRC_DMEM      = 2'b00;
    localparam logic [1:0] SRC_OTHER     = 2'b01;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic              r_owner;
    logic              r_last_owner;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic              r_found;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bus_err;

    logic              w_any_req;
    logic              w_winner;
    logic [1:0]        w_op_win;
    logic [ADDR_W-1:0] w_bico_win;
    logic              w_found_other;

    // Arbitration: a lone requester wins, a tie goes to the core not served last.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~r_last_owner;
        end else if (req1) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        w_op_win      = w_winner ? op1 : op0;
        w_bico_win    = w_winner ? bico1 : bico0;
        w_found_other = r_owner ? found0 : found1;
    end

    // Transaction sequencer; requests are only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_op         <= OP_READ_MISS;
            r_addr       <= {ADDR_W{1'b0}};
            r_found      <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
            r_bus_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Cleared here so an EVICT (no snoop) always sources dmem.
                    r_found <= 1'b0;
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_op    <= w_op_win;
                        r_addr  <= w_bico_win;
                        case (w_op_win)
                            OP_READ_MISS:  r_state <= S_SNOOP;
                            OP_WRITE_MISS: r_state <= S_SNOOP;
                            OP_INVALIDATE: r_state <= S_INVAL;
                            OP_EVICT:      r_state <= S_XFER;
                            default:       r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SNOOP: begin
                    r_found <= w_found_other;
                    r_state <= S_XFER;
                end
                S_XFER: begin
                    if (r_found || u_rdy) begin
                        r_state <= (r_op == OP_WRITE_MISS) ? S_INVAL : S_RELEASE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_INVAL: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_last_owner <= r_owner;
                    r_cnt        <= {CNT_W{1'b0}};
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered transaction context.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        search0  = 1'b0;
        search1  = 1'b0;
        inval0   = 1'b0;
        inval1   = 1'b0;
        datasel0 = SRC_DMEM;
        datasel1 = SRC_DMEM;
        boci     = {ADDR_W{1'b0}};
        bus_err  = r_bus_err;
        case (r_state)
            S_SNOOP: begin
                boci = r_addr;
                if (r_owner) begin
                    search0 = 1'b1;
                end else begin
                    search1 = 1'b1;
                end
            end
            S_XFER: begin
                boci = r_addr;
                if (r_owner) begin
                    grant1   = 1'b1;
                    datasel1 = r_found ? SRC_OTHER : SRC_DMEM;
                end else begin
                    grant0   = 1'b1;
                    datasel0 = r_found ? SRC_OTHER : SRC_DMEM;
                end
            end
            S_INVAL: begin
                boci = r_addr;
                if (r_owner) begin
                    grant1 = 1'b1;
                    inval0 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                    inval1 = 1'b1;
                end
            end
            default: begin
                boci = {ADDR_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each task drives one scenario and checks outputs
// on the falling edge against hand-computed values.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [12:0] bico0, bico1;
    logic        found0, found1;
    logic        u_rdy;
    logic        grant0, grant1;
    logic [12:0] boci;
    logic        search0, search1, inval0, inval1;
    logic [1:0]  datasel0, datasel1;
    logic        bus_err;

    int n_checks;
    int n_pass;
    logic [10:0] exp_o;

    bus_arbiter #(.ADDR_W(13), .TIMEOUT_CYC(255), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .bico0(bico0), .bico1(bico1), .found0(found0), .found1(found1),
        .u_rdy(u_rdy),
        .grant0(grant0), .grant1(grant1), .boci(boci),
        .search0(search0), .search1(search1), .inval0(inval0), .inval1(inval1),
        .datasel0(datasel0), .datasel1(datasel1), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {grant0,grant1}_{search0,search1}_{inval0,inval1}_datasel0_datasel1_bus_err
    function automatic logic [10:0] outs();
        return {grant0, grant1, search0, search1, inval0, inval1, datasel0, datasel1, bus_err};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (outs() !== 11'b00_00_00_00_00_0) $display("FAIL reset_outs: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h0000) $display("FAIL reset_boci: got %h expected %h", boci, 13'h0000);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_hit();
        req0 = 1'b1; op0 = 2'b00; bico0 = 13'h00A4; found1 = 1'b1;
        step();
        exp_o = 11'b00_01_00_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL rd_snoop_outs: got %b expected %b", outs(), exp_o);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h00A4) $display("FAIL rd_snoop_boci: got %h expected %h", boci, 13'h00A4);
        else n_pass++;
        step();
        exp_o = 11'b10_00_00_01_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL rd_xfer_outs: got %b expected %b", outs(), exp_o);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h00A4) $display("FAIL rd_xfer_boci: got %h expected %h", boci, 13'h00A4);
        else n_pass++;
        req0 = 1'b0; found1 = 1'b0;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL rd_release: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        step();
    endtask

    task automatic test_write_miss();
        req1 = 1'b1; op1 = 2'b01; bico1 = 13'h01F0; found0 = 1'b0; u_rdy = 1'b0;
        step();
        exp_o = 11'b00_10_00_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL wr_snoop: got %b expected %b", outs(), exp_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_o = 11'b01_00_00_00_00_0;
            n_checks++;
            if (outs() !== exp_o) $display("FAIL wr_xfer%0d: got %b expected %b", i, outs(), exp_o);
            else n_pass++;
            // Latched op/address must survive input changes mid-transaction.
            if (i == 1) begin
                bico1 = 13'h0000; op1 = 2'b11; req0 = 1'b0;
            end
            if (i == 3) begin
                u_rdy = 1'b1; req1 = 1'b0;
            end
        end
        step();
        u_rdy = 1'b0;
        exp_o = 11'b01_00_10_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL wr_inval: got %b expected %b", outs(), exp_o);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h01F0) $display("FAIL wr_inval_boci: got %h expected %h", boci, 13'h01F0);
        else n_pass++;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL wr_release: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        step();
    endtask

    task automatic test_tie();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; op0 = 2'b10; op1 = 2'b10;
        bico0 = 13'h0111; bico1 = 13'h0222;
        step();
        exp_o = 11'b10_00_01_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL tie_first: got %b expected %b", outs(), exp_o);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h0111) $display("FAIL tie_first_boci: got %h expected %h", boci, 13'h0111);
        else n_pass++;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL tie_release: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL tie_gap: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        step();
        exp_o = 11'b01_00_10_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL tie_second: got %b expected %b", outs(), exp_o);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h0222) $display("FAIL tie_second_boci: got %h expected %h", boci, 13'h0222);
        else n_pass++;
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        req0 = 1'b1; op0 = 2'b11; bico0 = 13'h0ABC; found1 = 1'b1; u_rdy = 1'b0;
        step();
        exp_o = 11'b10_00_00_00_00_0;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL ev_xfer_first: got %b expected %b", outs(), exp_o);
        else n_pass++;
        req0 = 1'b0;
        for (int i = 0; i < 254; i++) step();
        n_checks++;
        if (outs() !== exp_o) $display("FAIL ev_xfer_last: got %b expected %b", outs(), exp_o);
        else n_pass++;
        step();
        exp_o = 11'b00_00_00_00_00_1;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL ev_abort: got %b expected %b", outs(), exp_o);
        else n_pass++;
        found1 = 1'b0;
        step();
        step();
        n_checks++;
        if (bus_err !== 1'b1) $display("FAIL ev_sticky: got %b expected %b", bus_err, 1'b1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_xfer();
        req1 = 1'b1; op1 = 2'b11; bico1 = 13'h1234; u_rdy = 1'b0;
        step();
        exp_o = 11'b01_00_00_00_00_1;
        n_checks++;
        if (outs() !== exp_o) $display("FAIL rst_xfer: got %b expected %b", outs(), exp_o);
        else n_pass++;
        req1 = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL rst_mid_outs: got %b expected %b", outs(), 11'b0);
        else n_pass++;
        n_checks++;
        if (boci !== 13'h0000) $display("FAIL rst_mid_boci: got %h expected %h", boci, 13'h0000);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (outs() !== 11'b0) $display("FAIL rst_after: got %b expected %b", outs(), 11'b0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        bico0 = 13'h0000; bico1 = 13'h0000; found0 = 1'b0; found1 = 1'b0; u_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_read_hit();
        test_write_miss();
        test_tie();
        test_timeout();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
